// File: rtl/evt_pkg.sv
// Shared types and helpers for the 8-way event aggregator and its round-robin picker.
package evt_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = $clog2(N_SRC);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } evt_state_t;

  // Round-robin search: returns {hit, id}, scanning last+1 .. last+N_SRC (wrapping),
  // so the channel just served is considered last.
  function automatic logic [ID_W:0] rr_next(input logic [N_SRC-1:0] req,
                                            input logic [ID_W-1:0]  last);
    logic            hit;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] idx;
    hit = 1'b0;
    id  = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = last + ID_W'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        id  = idx;
      end else begin
        hit = hit;
      end
    end
    return {hit, id};
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker: first requesting channel after last_id.
module rr_pick_8
  import evt_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             hit,
  output logic [ID_W-1:0]  id
);

  // Pick the next requester in rotating priority order
  always_comb begin
    {hit, id} = rr_next(req, last_id);
  end

endmodule

// File: rtl/event_aggregator_8way.sv
// Synchronises 8 asynchronous event lines, latches sticky maskable pending bits and
// serves them round-robin as a stream of channel IDs over a valid/ready handshake.
module event_aggregator_8way
  import evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             clr_all,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_SRC-1:0] pending,
  output logic             any_pending,
  output logic [N_SRC-1:0] overflow
);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_r;
  logic [N_SRC-1:0] prev_r;
  logic [N_SRC-1:0] sync_s;
  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] ovf_set_s;
  logic [N_SRC-1:0] req_s;
  logic             hs_s;
  logic             pick_hit_s;
  logic [ID_W-1:0]  pick_id_s;
  logic [ID_W-1:0]  last_id_r;
  evt_state_t       state_r;

  // Metastability chain per line, plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= src_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_r[j] <= sync_r[j-1];
      end
      prev_r <= sync_s;
    end
  end

  // Event detection, handshake clear and overflow terms
  always_comb begin
    sync_s = sync_r[SYNC_STAGES-1];
    rise_s = sync_s & ~prev_r;
    hs_s   = evt_valid & evt_ready;
    if (hs_s) begin
      clr_s = {{(N_SRC-1){1'b0}}, 1'b1} << evt_id;
    end else begin
      clr_s = '0;
    end
    if (EDGE_MODE) begin
      set_s     = rise_s & mask;
      ovf_set_s = rise_s & mask & pending & ~clr_s;
    end else begin
      set_s     = sync_s & mask;
      ovf_set_s = '0;
    end
  end

  // Sticky pending and overflow bits; a new event beats a same-cycle grant clear,
  // while clr_all beats everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= '0;
    end else if (clr_all) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr_s) | set_s;
      overflow <= overflow | ovf_set_s;
    end
  end

  assign req_s       = pending & mask;
  assign any_pending = |req_s;

  rr_pick_8 u_pick (
    .req     (req_s),
    .last_id (last_id_r),
    .hit     (pick_hit_s),
    .id      (pick_id_s)
  );

  // Offer FSM: latch a pick in IDLE, hold it stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      last_id_r <= ID_W'(N_SRC - 1);
    end else if (clr_all) begin
      state_r   <= IDLE;
      evt_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_hit_s) begin
            evt_id    <= pick_id_s;
            evt_valid <= 1'b1;
            state_r   <= OFFER;
          end else begin
            evt_valid <= 1'b0;
          end
        end
        OFFER: begin
          if (hs_s) begin
            last_id_r <= evt_id;
            evt_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            evt_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_aggregator_8way.sv
// Self-checking bench for event_aggregator_8way: scoreboard of expected grant IDs
// plus directed checks on latency, overflow, masking, clr_all, async reset and level mode.
module tb_event_aggregator_8way;
  import evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_in, mask, pending, overflow;
  logic       clr_all, evt_ready, evt_valid, any_pending;
  logic [2:0] evt_id;

  logic [7:0] src_l, pend_l, ovf_l;
  logic       ready_l, valid_l, any_l;
  logic [2:0] id_l;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lvl_hs = 0;
  bit lvl_on = 1'b0;
  int exp_q[$];
  int hs_q[$];

  always #5 clk = ~clk;

  event_aggregator_8way #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .mask(mask), .clr_all(clr_all),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pending(pending), .any_pending(any_pending), .overflow(overflow)
  );

  event_aggregator_8way #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .src_in(src_l), .mask(8'hFF), .clr_all(1'b0),
    .evt_valid(valid_l), .evt_id(id_l), .evt_ready(ready_l),
    .pending(pend_l), .any_pending(any_l), .overflow(ovf_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    src_in = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!evt_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_valid", 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
    check_eq("drain_idle", 32'(evt_valid), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every accepted ID against the expected order
  always @(negedge clk) begin
    if (rst_n && !clr_all && evt_valid && evt_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(evt_id), 32'hFFFF_FFFF);
      else check_eq("sb_id", 32'(evt_id), 32'(exp_q.pop_front()));
    end
    if (rst_n && lvl_on && valid_l && ready_l) begin
      lvl_hs++;
      check_eq("lvl_id", 32'(id_l), 32'd5);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; src_in = 8'h00; mask = 8'hFF; clr_all = 1'b0; evt_ready = 1'b0;
    src_l = 8'h00; ready_l = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_id", 32'(evt_id), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_any", 32'(any_pending), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single edge on line 3, latency and clear on handshake
    src_in[3] = 1'b1;
    tick();
    tick();
    tick();
    check_eq("t1_pending", 32'(pending), 32'h08);
    check_eq("t1_valid_early", 32'(evt_valid), 32'd0);
    tick();
    check_eq("t1_valid", 32'(evt_valid), 32'd1);
    check_eq("t1_id", 32'(evt_id), 32'd3);
    exp_q.push_back(3);
    evt_ready = 1'b1;
    src_in[3] = 1'b0;
    tick();
    check_eq("t1_pend_clr", 32'(pending), 32'd0);
    check_eq("t1_valid_low", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // 2: simultaneous edges served in round-robin order with one idle bubble each
    do_reset();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7);
    hs_q.delete();
    evt_ready = 1'b1;
    src_in = 8'hA5;
    tick();
    tick();
    src_in = 8'h00;
    wait_drain(40);
    check_eq("t2_hs_count", 32'(hs_q.size()), 32'd4);
    for (int i = 1; i < hs_q.size(); i++) check_eq("t2_gap", 32'(hs_q[i] - hs_q[i-1]), 32'd2);
    tick();
    check_eq("t2_any", 32'(any_pending), 32'd0);

    // 3: overflow while offer is held, then clr_all
    evt_ready = 1'b0;
    src_in[2] = 1'b1;
    tick();
    tick();
    src_in[2] = 1'b0;
    wait_valid(10);
    check_eq("t3_id", 32'(evt_id), 32'd2);
    src_in[2] = 1'b1;
    repeat (4) tick();
    src_in[2] = 1'b0;
    check_eq("t3_overflow", 32'(overflow), 32'h04);
    check_eq("t3_valid_held", 32'(evt_valid), 32'd1);
    check_eq("t3_id_held", 32'(evt_id), 32'd2);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check_eq("t3_ovf_clr", 32'(overflow), 32'd0);
    check_eq("t3_valid_clr", 32'(evt_valid), 32'd0);
    check_eq("t3_pend_clr", 32'(pending), 32'd0);

    // 4: masked-off edge dropped, then served once enabled
    mask = 8'hFE;
    src_in[0] = 1'b1;
    tick();
    tick();
    src_in[0] = 1'b0;
    repeat (4) tick();
    check_eq("t4_pend_masked", 32'(pending), 32'd0);
    check_eq("t4_any_masked", 32'(any_pending), 32'd0);
    check_eq("t4_valid_masked", 32'(evt_valid), 32'd0);
    mask = 8'hFF;
    exp_q.push_back(0);
    evt_ready = 1'b1;
    src_in[0] = 1'b1;
    tick();
    tick();
    src_in[0] = 1'b0;
    wait_drain(20);

    // 5: grant on id 4 coincides with a new edge on line 4
    evt_ready = 1'b0;
    src_in[4] = 1'b1;
    tick();
    tick();
    src_in = 8'h42;
    tick();
    tick();
    src_in = 8'h00;
    repeat (3) tick();
    check_eq("t5_id", 32'(evt_id), 32'd4);
    check_eq("t5_pending", 32'(pending), 32'h52);
    exp_q.push_back(4);
    src_in[4] = 1'b1;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    src_in = 8'h00;
    check_eq("t5_pend_kept", 32'(pending), 32'h52);
    check_eq("t5_valid_bubble", 32'(evt_valid), 32'd0);
    exp_q.push_back(6); exp_q.push_back(1); exp_q.push_back(4);
    evt_ready = 1'b1;
    wait_drain(30);

    // 6: asynchronous reset in the middle of an offer
    evt_ready = 1'b0;
    src_in[3] = 1'b1;
    tick();
    tick();
    src_in[3] = 1'b0;
    wait_valid(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid_async", 32'(evt_valid), 32'd0);
    check_eq("t6_pend_async", 32'(pending), 32'd0);
    check_eq("t6_id_async", 32'(evt_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Level mode: line held high is re-offered after every grant
    lvl_on = 1'b1;
    ready_l = 1'b1;
    src_l[5] = 1'b1;
    repeat (20) tick();
    lvl_on = 1'b0;
    ready_l = 1'b0;
    src_l = 8'h00;
    check_eq("lvl_reoffer", 32'(lvl_hs >= 6), 32'd1);
    check_eq("lvl_overflow", 32'(ovf_l), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
